msg_word_counter: RTL and testbench
===================================

# msg_word_counter

Parametrised per-message word counter for the AES message path, sitting between the message source and the block that frames messages into AES blocks. Counts accepted words between start-of-packet and end-of-packet, exposes a live running count, and on end-of-packet pushes the final message length (with a saturation flag) into a small internal FIFO drained over a valid/ready interface. Unlike a free-running counter, it applies backpressure and tracks message state with a two-state FSM.

## Interface
Parameters:
- CNT_W, 8: width of the word counter and of the reported length.
- FIFO_DEPTH, 4: number of length records buffered; power of two, at least 2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- msg_in_valid  in  1  input word present.
- msg_in_sop  in  1  word is first of message; qualified by msg_in_valid.
- msg_in_eop  in  1  word is last of message; qualified by msg_in_valid.
- msg_in_ready  out  1  word accepted when msg_in_valid and msg_in_ready are both high.
- cntr  out  CNT_W  live count of the current message, including the most recently accepted word.
- len_valid  out  1  length record available.
- len_data  out  CNT_W  message length in words.
- len_sat  out  1  length saturated at 2^CNT_W-1.
- len_ready  in  1  consumer takes the record when len_valid and len_ready are both high.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  records currently buffered.
- msg_err  out  1  protocol error pulse; present only when MSG_WORD_CNT_ERR_EN is defined.

## Operation
- Accept means msg_in_valid && msg_in_ready. msg_in_ready = ~fifo_full; it is a function of registered state only, with no combinational path from len_ready.
- FSM IDLE/IN_MSG; reset state IDLE.
  - IDLE, accepted word: cntr <= 1, sat <= 0. If eop, push {1,0} and stay IDLE. Otherwise go to IN_MSG. A word without sop is an implicit sop.
  - IN_MSG, accepted word without sop: cntr <= cntr+1 saturating at 2^CNT_W-1. sat <= 1 when the increment would overflow. On eop, push {next count, next sat} and go to IDLE.
  - IN_MSG, accepted word with sop: the previous message is abandoned with no push. cntr <= 1, sat <= 0. If eop is also set, push {1,0} and go to IDLE; otherwise stay in IN_MSG.
- The pushed length always includes the eop word. sop and eop on the same word gives length 1.
- cntr holds its value between messages until the next accepted word.
- FIFO: push and pop in the same cycle are allowed while non-empty, and the level is unchanged. Push while full cannot occur, because ready is low then.
- Reset values: cntr=0, len_valid=0, len_data=0, len_sat=0, fifo_level=0, msg_in_ready=1, msg_err=0, FSM=IDLE.
- Reset asserted mid-message discards the partial count and all buffered records.

## Timing
- Accept at edge N updates cntr at N (visible in cycle N+1).
- eop accepted at edge N sets len_valid high in cycle N+1 when the FIFO was empty. Otherwise the record queues behind earlier ones.
- len_data and len_sat are stable while len_valid is high and len_ready is low.
- Pop at edge N with FIFO full raises msg_in_ready in cycle N+1.
- With len_ready held high, sustained throughput is one word per cycle, including back-to-back single-word messages.

## Configuration
- MSG_WORD_CNT_ERR_EN defined: adds the msg_err port. msg_err is a one-cycle registered pulse, asserted the cycle after any of:
  - an accepted word in IDLE without sop;
  - an accepted sop word in IN_MSG (abandoned message).
- Counting and push behaviour is identical with or without the macro.
- Undefined: the port and its logic are absent.

## Structure
- Shared package msg_word_counter_pkg contains:
  - typedef fsm_state_t {IDLE, IN_MSG};
  - typedef len_rec_t {logic sat; logic [CNT_W-1:0] len}, parametrised through a localparam default of 8, with the module casting;
  - function sat_inc(cnt, max).
- Sub-module len_fifo, a synchronous FIFO parametrised in width and depth. It outputs full, empty and level, and has pointers one bit wider than the address.

## Test plan
- Reset, then a 3-word message (sop, mid, eop), len_ready=1 -> cntr 1,2,3; len_valid one cycle after eop with len_data=3, len_sat=0.
- Single word with sop=eop=1 on 4 consecutive cycles -> four records of length 1, msg_in_ready stays high, no stall.
- len_ready=0, FIFO_DEPTH=4, five 1-word messages -> fifo_level reaches 4 and msg_in_ready goes low. Raise len_ready -> records pop in order and ready returns the cycle after the first pop.
- CNT_W=4, 20-word message -> cntr sticks at 15; record len_data=15, len_sat=1. The next 2-word message reports len_data=2, len_sat=0.
- sop at word 3 of an unfinished message, then 2 more words ending in eop -> single record length 3. With MSG_WORD_CNT_ERR_EN defined, one msg_err pulse is seen.
- rst asserted mid-message with 2 records queued -> all outputs return to reset values asynchronously. A following 2-word message reports length 2.

Source files
------------

// File: rtl/msg_word_counter_pkg.sv
// Shared types and helpers for the AES message-path word counter.
package msg_word_counter_pkg;

  localparam int LEN_W_DEF = 8;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    IN_MSG = 1'b1
  } fsm_state_t;

  typedef struct packed {
    logic                 sat;
    logic [LEN_W_DEF-1:0] len;
  } len_rec_t;

  // Increment that sticks at max instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic [31:0] max);
    return (cnt >= max) ? max : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/msg_word_counter_len_fifo.sv
// Synchronous FIFO for length records; pointers carry one extra wrap bit so
// full and empty are distinguishable without a separate counter.
module len_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Head is forced to zero when empty so the reported record is clean after reset.
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/msg_word_counter.sv
// Per-message word counter with length FIFO and backpressure.
// Optional protocol-error pulse output enabled by MSG_WORD_CNT_ERR_EN.
module msg_word_counter
  import msg_word_counter_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          msg_in_valid,
  input  logic                          msg_in_sop,
  input  logic                          msg_in_eop,
  output logic                          msg_in_ready,
  output logic [CNT_W-1:0]              cntr,
  output logic                          len_valid,
  output logic [CNT_W-1:0]              len_data,
  output logic                          len_sat,
  input  logic                          len_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef MSG_WORD_CNT_ERR_EN
  ,
  output logic                          msg_err
`endif
);

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  fsm_state_t       state, state_nxt;
  logic [CNT_W-1:0] cntr_nxt;
  logic             sat, sat_nxt;
  logic             push;
  logic             accept;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W:0]   rec_wr;
  logic [CNT_W:0]   rec_rd;

  assign msg_in_ready = ~fifo_full;
  assign accept       = msg_in_valid && msg_in_ready;
  assign len_valid    = ~fifo_empty;

  always_comb begin
    state_nxt = state;
    cntr_nxt  = cntr;
    sat_nxt   = sat;
    push      = 1'b0;
    if (accept) begin
      // A word in IDLE always opens a message; a sop in IN_MSG drops the old one.
      if (state == IDLE || msg_in_sop) begin
        cntr_nxt = CNT_W'(1);
        sat_nxt  = 1'b0;
      end else begin
        cntr_nxt = CNT_W'(sat_inc(32'(cntr), CNT_MAX));
        sat_nxt  = sat | (cntr == CNT_W'(CNT_MAX));
      end
      if (msg_in_eop) begin
        push      = 1'b1;
        state_nxt = IDLE;
      end else begin
        state_nxt = IN_MSG;
      end
    end
  end

  assign rec_wr = {sat_nxt, cntr_nxt};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cntr  <= '0;
      sat   <= 1'b0;
    end else begin
      state <= state_nxt;
      cntr  <= cntr_nxt;
      sat   <= sat_nxt;
    end
  end

  len_fifo #(
    .WIDTH (CNT_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_len_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (rec_wr),
    .pop     (len_valid && len_ready),
    .rd_data (rec_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign len_sat  = rec_rd[CNT_W];
  assign len_data = rec_rd[CNT_W-1:0];

`ifdef MSG_WORD_CNT_ERR_EN
  // Implicit sop in IDLE or an abandoned message each flag one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msg_err <= 1'b0;
    end else begin
      msg_err <= accept && ((state == IDLE && !msg_in_sop) ||
                            (state == IN_MSG && msg_in_sop));
    end
  end
`endif

endmodule

// File: tb/tb_msg_word_counter.sv
// Bench for msg_word_counter: directed table, corner sequences and random
// traffic against a queue-based message model (CNT_W=8 and CNT_W=4 instances).
module tb_msg_word_counter;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic msg_in_valid = 1'b0;
  logic msg_in_sop = 1'b0;
  logic msg_in_eop = 1'b0;
  logic len_ready = 1'b0;

  logic       r8, v8, s8;
  logic [7:0] c8, d8;
  logic [2:0] l8;
  logic       r4, v4, s4;
  logic [3:0] c4, d4;
  logic [2:0] l4;
  logic       e8, e4;

  always #5 clk = ~clk;

  msg_word_counter #(.CNT_W(8), .FIFO_DEPTH(DEPTH)) dut8 (
    .clk(clk), .rst(rst), .msg_in_valid(msg_in_valid), .msg_in_sop(msg_in_sop),
    .msg_in_eop(msg_in_eop), .msg_in_ready(r8), .cntr(c8), .len_valid(v8),
    .len_data(d8), .len_sat(s8), .len_ready(len_ready), .fifo_level(l8)
`ifdef MSG_WORD_CNT_ERR_EN
    , .msg_err(e8)
`endif
  );

  msg_word_counter #(.CNT_W(4), .FIFO_DEPTH(DEPTH)) dut4 (
    .clk(clk), .rst(rst), .msg_in_valid(msg_in_valid), .msg_in_sop(msg_in_sop),
    .msg_in_eop(msg_in_eop), .msg_in_ready(r4), .cntr(c4), .len_valid(v4),
    .len_data(d4), .len_sat(s4), .len_ready(len_ready), .fifo_level(l4)
`ifdef MSG_WORD_CNT_ERR_EN
    , .msg_err(e4)
`endif
  );

`ifndef MSG_WORD_CNT_ERR_EN
  assign e8 = 1'b0;
  assign e4 = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Message-level model: unbounded word count, records as (sat<<16 | len).
  int mcnt   [2];
  bit minmsg [2];
  bit merr   [2];
  int mq     [2][$];
  int mmax   [2] = '{255, 15};

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mcnt[i] = 0; minmsg[i] = 0; merr[i] = 0; mq[i].delete();
    end
  endtask

  task automatic model_edge(input int i, input bit v, input bit s, input bit e, input bit lr);
    int  sz;
    bit  acc, pop;
    int  len;
    sz  = mq[i].size();
    acc = v && (sz < DEPTH);
    pop = (sz > 0) && lr;
    merr[i] = acc && ((!minmsg[i] && !s) || (minmsg[i] && s));
    if (pop) void'(mq[i].pop_front());
    if (acc) begin
      if (!minmsg[i] || s) mcnt[i] = 1;
      else                 mcnt[i] = mcnt[i] + 1;
      if (e) begin
        len = (mcnt[i] > mmax[i]) ? mmax[i] : mcnt[i];
        mq[i].push_back(((mcnt[i] > mmax[i]) ? 65536 : 0) + len);
        minmsg[i] = 0;
      end else begin
        minmsg[i] = 1;
      end
    end
  endtask

  task automatic check_model();
    int a_c, a_v, a_d, a_s, a_l, a_r, a_e;
    int x_v, x_c, front;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        a_c = c8; a_v = v8; a_d = d8; a_s = s8; a_l = l8; a_r = r8; a_e = e8;
      end else begin
        a_c = c4; a_v = v4; a_d = d4; a_s = s4; a_l = l4; a_r = r4; a_e = e4;
      end
      x_v = (mq[i].size() > 0) ? 1 : 0;
      x_c = (mcnt[i] > mmax[i]) ? mmax[i] : mcnt[i];
      chk($sformatf("model%0d cntr", i), a_c, x_c);
      chk($sformatf("model%0d len_valid", i), a_v, x_v);
      chk($sformatf("model%0d fifo_level", i), a_l, mq[i].size());
      chk($sformatf("model%0d msg_in_ready", i), a_r, (mq[i].size() < DEPTH) ? 1 : 0);
      if (x_v == 1) begin
        front = mq[i][0];
        chk($sformatf("model%0d len_data", i), a_d, front & 16'hFFFF);
        chk($sformatf("model%0d len_sat", i), a_s, front >> 16);
      end
`ifdef MSG_WORD_CNT_ERR_EN
      chk($sformatf("model%0d msg_err", i), a_e, merr[i] ? 1 : 0);
`endif
    end
  endtask

  task automatic step(input bit v, input bit s, input bit e, input bit lr);
    msg_in_valid = v; msg_in_sop = s; msg_in_eop = e; len_ready = lr;
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_edge(i, v, s, e, lr);
    #1;
    check_model();
  endtask

  typedef struct {
    bit v, s, e, lr;
    int cntr, lv, ld, lvl, rdy;
  } vec_t;

  vec_t tbl [18];
  int   err_cnt;

  initial begin
    tbl[0]  = '{1,1,0,1, 1,0,0,0,1};
    tbl[1]  = '{1,0,0,1, 2,0,0,0,1};
    tbl[2]  = '{1,0,1,1, 3,1,3,1,1};
    tbl[3]  = '{0,0,0,1, 3,0,0,0,1};
    tbl[4]  = '{1,1,1,1, 1,1,1,1,1};
    tbl[5]  = '{1,1,1,1, 1,1,1,1,1};
    tbl[6]  = '{1,1,1,1, 1,1,1,1,1};
    tbl[7]  = '{1,1,1,1, 1,1,1,1,1};
    tbl[8]  = '{0,0,0,1, 1,0,0,0,1};
    tbl[9]  = '{1,1,1,0, 1,1,1,1,1};
    tbl[10] = '{1,1,1,0, 1,1,1,2,1};
    tbl[11] = '{1,1,1,0, 1,1,1,3,1};
    tbl[12] = '{1,1,1,0, 1,1,1,4,0};
    tbl[13] = '{1,1,1,0, 1,1,1,4,0};
    tbl[14] = '{0,0,0,1, 1,1,1,3,1};
    tbl[15] = '{0,0,0,1, 1,1,1,2,1};
    tbl[16] = '{0,0,0,1, 1,1,1,1,1};
    tbl[17] = '{0,0,0,1, 1,0,0,0,1};

    model_reset();
    #2 rst = 1'b1;
    #10;
    chk("reset cntr", c8, 0);
    chk("reset len_valid", v8, 0);
    chk("reset len_data", d8, 0);
    chk("reset len_sat", s8, 0);
    chk("reset fifo_level", l8, 0);
    chk("reset msg_in_ready", r8, 1);
    chk("reset msg_err", e8, 0);
    @(posedge clk); #1 rst = 1'b0;

    for (int k = 0; k < 18; k++) begin
      step(tbl[k].v, tbl[k].s, tbl[k].e, tbl[k].lr);
      chk($sformatf("tbl%0d cntr", k), c8, tbl[k].cntr);
      chk($sformatf("tbl%0d len_valid", k), v8, tbl[k].lv);
      if (tbl[k].lv == 1) chk($sformatf("tbl%0d len_data", k), d8, tbl[k].ld);
      chk($sformatf("tbl%0d fifo_level", k), l8, tbl[k].lvl);
      chk($sformatf("tbl%0d msg_in_ready", k), r8, tbl[k].rdy);
    end

    // 20-word message on the 4-bit instance saturates; the next one does not.
    for (int w = 0; w < 20; w++) step(1, w == 0, w == 19, 1);
    chk("sat cntr4", c4, 15);
    chk("sat len_valid4", v4, 1);
    chk("sat len_data4", d4, 15);
    chk("sat len_sat4", s4, 1);
    chk("sat len_data8", d8, 20);
    step(1, 1, 0, 1);
    step(1, 0, 1, 1);
    chk("post-sat len_data4", d4, 2);
    chk("post-sat len_sat4", s4, 0);
    step(0, 0, 0, 1);

    // sop on the third word abandons the first message.
    err_cnt = 0;
    step(1, 1, 0, 1); err_cnt += e8;
    step(1, 0, 0, 1); err_cnt += e8;
    step(1, 1, 0, 1); err_cnt += e8;
    step(1, 0, 0, 1); err_cnt += e8;
    chk("abandon no record", v8, 0);
    step(1, 0, 1, 1); err_cnt += e8;
    chk("abandon len_data", d8, 3);
    chk("abandon fifo_level", l8, 1);
    step(0, 0, 0, 1); err_cnt += e8;
`ifdef MSG_WORD_CNT_ERR_EN
    chk("abandon err pulses", err_cnt, 1);
`endif

    // Asynchronous reset mid-message with records queued.
    step(1, 1, 1, 0);
    step(1, 1, 1, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    chk("pre-rst fifo_level", l8, 2);
    #1 rst = 1'b1;
    #1;
    chk("mid-rst cntr", c8, 0);
    chk("mid-rst len_valid", v8, 0);
    chk("mid-rst len_data", d8, 0);
    chk("mid-rst fifo_level", l8, 0);
    chk("mid-rst msg_in_ready", r8, 1);
    chk("mid-rst fifo_level4", l4, 0);
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
    step(1, 1, 0, 1);
    step(1, 0, 1, 1);
    chk("post-rst len_valid", v8, 1);
    chk("post-rst len_data", d8, 2);

    // Random traffic: short messages, then long ones to reach saturation.
    for (int n = 0; n < 1200; n++) begin
      bit rv, rs, re, rl;
      rv = ($urandom_range(0, 9) < 7);
      rs = ($urandom_range(0, 9) < 2);
      rl = ($urandom_range(0, 9) < 6);
      if (n < 600) re = ($urandom_range(0, 99) < 25);
      else         re = ($urandom_range(0, 99) < 3);
      if (n >= 600) rs = ($urandom_range(0, 99) < 2);
      step(rv, rs, re, rl);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
